// File: rtl/conv_tile_sched.sv
// ---------------------------------------------------------------------------
// conv_tile_sched
//
// Tile-loop scheduler for the convolution accelerator. It walks the output
// tiles (m outermost, then row, then col) and, inside each output tile, the
// input-channel tiles (n innermost). For every n-tile it runs one load and one
// compute. After the last n-tile of an output tile it runs one store. The
// engines are driven through start/done pulse handshakes. The scheduler runs
// once per layer, from a start pulse to a task_done pulse.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    layer start pulse (ignored while busy)
//   load_start / load_done   load engine handshake (in_fm + weights)
//   comp_start / comp_done   compute engine handshake (one n-tile)
//   store_start / store_done store engine handshake (out_fm tile)
//   tile_base_*              origin of the current tile (m, row, col, n)
//   tile_len_*               edge-clipped extent of the current tile
//   tile_first_n             current n-tile is the first (accumulator clears)
//   tile_last_n              current n-tile is the last (store follows)
//   busy                     from the cycle after start through task_done
//   task_done                one-cycle pulse when the layer is finished
// ---------------------------------------------------------------------------
module conv_tile_sched #(
    parameter int CW = 8,
    parameter int M  = 32,
    parameter int R  = 32,
    parameter int C  = 32,
    parameter int N  = 32,
    parameter int Tm = 8,
    parameter int Tr = 8,
    parameter int Tc = 8,
    parameter int Tn = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          load_start,
    input  logic          load_done,
    output logic          comp_start,
    input  logic          comp_done,
    output logic          store_start,
    input  logic          store_done,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic [CW-1:0] tile_base_n,
    output logic [CW-1:0] tile_len_m,
    output logic [CW-1:0] tile_len_row,
    output logic [CW-1:0] tile_len_col,
    output logic [CW-1:0] tile_len_n,
    output logic          tile_first_n,
    output logic          tile_last_n,
    output logic          busy,
    output logic          task_done
);

    typedef enum logic [2:0] {IDLE, LOAD, COMP, STORE, FIN} state_t;

    // Limits and tile sizes are carried one bit wider than the bases so
    // that base + tile never overflows.
    localparam logic [CW:0] LIM_M = (CW+1)'(M);
    localparam logic [CW:0] LIM_R = (CW+1)'(R);
    localparam logic [CW:0] LIM_C = (CW+1)'(C);
    localparam logic [CW:0] LIM_N = (CW+1)'(N);
    localparam logic [CW:0] T_M   = (CW+1)'(Tm);
    localparam logic [CW:0] T_R   = (CW+1)'(Tr);
    localparam logic [CW:0] T_C   = (CW+1)'(Tc);
    localparam logic [CW:0] T_N   = (CW+1)'(Tn);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] nb_m, nb_row, nb_col, nb_n;
    logic          nx_load_start, nx_comp_start, nx_store_start;
    logic          nx_busy, nx_task_done;
    logic          wrap_m, wrap_row, wrap_col, last_tile;

    // Extent of a tile at the given base, clipped at the layer edge.
    function automatic logic [CW-1:0] clip_len(input logic [CW-1:0] base,
                                               input logic [CW:0]   tile,
                                               input logic [CW:0]   lim);
        logic [CW:0] ext;
        ext = {1'b0, base};
        return (ext + tile > lim) ? CW'(lim - ext) : CW'(tile);
    endfunction

    // True when stepping this base by its tile would leave the layer.
    function automatic logic wraps(input logic [CW-1:0] base,
                                   input logic [CW:0]   tile,
                                   input logic [CW:0]   lim);
        return ({1'b0, base} + tile) >= lim;
    endfunction

    // The last output tile is where the m, row and col loops all wrap at once.
    always_comb begin
        wrap_m    = wraps(tile_base_m,   T_M, LIM_M);
        wrap_row  = wraps(tile_base_row, T_R, LIM_R);
        wrap_col  = wraps(tile_base_col, T_C, LIM_C);
        last_tile = wrap_m & wrap_row & wrap_col;
    end

    // State register plus all registered outputs. The lengths and n-flags
    // are derived from the bases that are being loaded, so they are valid
    // in the same cycle as the new bases and the following start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tile_base_m   <= '0;
            tile_base_row <= '0;
            tile_base_col <= '0;
            tile_base_n   <= '0;
            tile_len_m    <= clip_len('0, T_M, LIM_M);
            tile_len_row  <= clip_len('0, T_R, LIM_R);
            tile_len_col  <= clip_len('0, T_C, LIM_C);
            tile_len_n    <= clip_len('0, T_N, LIM_N);
            tile_first_n  <= 1'b1;
            tile_last_n   <= wraps('0, T_N, LIM_N);
            load_start    <= 1'b0;
            comp_start    <= 1'b0;
            store_start   <= 1'b0;
            busy          <= 1'b0;
            task_done     <= 1'b0;
        end else begin
            state         <= state_nxt;
            tile_base_m   <= nb_m;
            tile_base_row <= nb_row;
            tile_base_col <= nb_col;
            tile_base_n   <= nb_n;
            tile_len_m    <= clip_len(nb_m,   T_M, LIM_M);
            tile_len_row  <= clip_len(nb_row, T_R, LIM_R);
            tile_len_col  <= clip_len(nb_col, T_C, LIM_C);
            tile_len_n    <= clip_len(nb_n,   T_N, LIM_N);
            tile_first_n  <= (nb_n == '0);
            tile_last_n   <= wraps(nb_n, T_N, LIM_N);
            load_start    <= nx_load_start;
            comp_start    <= nx_comp_start;
            store_start   <= nx_store_start;
            busy          <= nx_busy;
            task_done     <= nx_task_done;
        end
    end

    // Next-state logic. Each state only listens to its own done pulse, so
    // done pulses arriving in any other state fall through unnoticed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = LOAD;
            LOAD:    if (load_done)  state_nxt = COMP;
            COMP:    if (comp_done)  state_nxt = tile_last_n ? STORE : LOAD;
            STORE:   if (store_done) state_nxt = last_tile ? FIN : LOAD;
            FIN:                     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Output logic: computes the values the output registers take on the
    // next edge. Start pulses are issued on the edge that enters a state,
    // together with any base advance, so each pulse lasts one cycle.
    // The output-tile advance is a col-innermost odometer with m outermost.
    always_comb begin
        nb_m           = tile_base_m;
        nb_row         = tile_base_row;
        nb_col         = tile_base_col;
        nb_n           = tile_base_n;
        nx_load_start  = 1'b0;
        nx_comp_start  = 1'b0;
        nx_store_start = 1'b0;
        nx_task_done   = 1'b0;
        nx_busy        = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    nb_m          = '0;
                    nb_row        = '0;
                    nb_col        = '0;
                    nb_n          = '0;
                    nx_load_start = 1'b1;
                    nx_busy       = 1'b1;
                end
            end
            LOAD: begin
                if (load_done) nx_comp_start = 1'b1;
            end
            COMP: begin
                if (comp_done) begin
                    if (!tile_last_n) begin
                        nb_n          = CW'({1'b0, tile_base_n} + T_N);
                        nx_load_start = 1'b1;
                    end else begin
                        nx_store_start = 1'b1;
                    end
                end
            end
            STORE: begin
                if (store_done) begin
                    if (last_tile) begin
                        nx_task_done = 1'b1;
                    end else begin
                        nb_n          = '0;
                        nx_load_start = 1'b1;
                        if (!wrap_col) begin
                            nb_col = CW'({1'b0, tile_base_col} + T_C);
                        end else begin
                            nb_col = '0;
                            if (!wrap_row) begin
                                nb_row = CW'({1'b0, tile_base_row} + T_R);
                            end else begin
                                nb_row = '0;
                                nb_m   = CW'({1'b0, tile_base_m} + T_M);
                            end
                        end
                    end
                end
            end
            FIN: begin
                nb_m    = '0;
                nb_row  = '0;
                nb_col  = '0;
                nb_n    = '0;
                nx_busy = 1'b0;
            end
            default: begin
                nx_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_tile_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_tile_sched
//
// Self-checking bench for conv_tile_sched. Two instances are built:
//   inst 0: M=R=C=N=16, all tiles 8 (full walk, handshake and reset cases)
//   inst 1: M=R=8, C=20, N=24, all tiles 8 (ragged cols, multi n-tile flags)
// A cycle-by-cycle vector table covers the hand-checked handshake corners.
// Whole-layer runs answer the engines with fixed, immediate or random
// latency, and compare every tile against a nested-loop reference list.
// ---------------------------------------------------------------------------
module tb_conv_tile_sched;

    typedef struct {
        bit rst, start, ld, cd, sd;
        bit ls, cs, ss, busy, td;
        int bn, bc;
        bit first, last;
    } vec_t;

    typedef struct {
        int  m, row, col, n;
        int  lm, lr, lc, ln;
        bit  first, last;
    } tile_t;

    logic       clk;
    logic       rst_s   [2];
    logic       start_s [2];
    logic       spur_s  [2];
    logic       ld_s    [2];
    logic       cd_s    [2];
    logic       sd_s    [2];
    logic       ls_o    [2];
    logic       cs_o    [2];
    logic       ss_o    [2];
    logic       first_o [2];
    logic       last_o  [2];
    logic       busy_o  [2];
    logic       td_o    [2];
    logic [7:0] bm [2], br [2], bc [2], bn [2];
    logic [7:0] lm [2], lr [2], lc [2], ln [2];

    int pm [2], pr [2], pc [2], pn [2];
    int tm [2], tr [2], tc [2], tn [2];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    conv_tile_sched #(
        .CW(8), .M(16), .R(16), .C(16), .N(16),
        .Tm(8), .Tr(8), .Tc(8), .Tn(8)
    ) dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0] | spur_s[0]),
        .load_start(ls_o[0]), .load_done(ld_s[0]),
        .comp_start(cs_o[0]), .comp_done(cd_s[0]),
        .store_start(ss_o[0]), .store_done(sd_s[0]),
        .tile_base_m(bm[0]), .tile_base_row(br[0]),
        .tile_base_col(bc[0]), .tile_base_n(bn[0]),
        .tile_len_m(lm[0]), .tile_len_row(lr[0]),
        .tile_len_col(lc[0]), .tile_len_n(ln[0]),
        .tile_first_n(first_o[0]), .tile_last_n(last_o[0]),
        .busy(busy_o[0]), .task_done(td_o[0])
    );

    conv_tile_sched #(
        .CW(8), .M(8), .R(8), .C(20), .N(24),
        .Tm(8), .Tr(8), .Tc(8), .Tn(8)
    ) dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1] | spur_s[1]),
        .load_start(ls_o[1]), .load_done(ld_s[1]),
        .comp_start(cs_o[1]), .comp_done(cd_s[1]),
        .store_start(ss_o[1]), .store_done(sd_s[1]),
        .tile_base_m(bm[1]), .tile_base_row(br[1]),
        .tile_base_col(bc[1]), .tile_base_n(bn[1]),
        .tile_len_m(lm[1]), .tile_len_row(lr[1]),
        .tile_len_col(lc[1]), .tile_len_n(ln[1]),
        .tile_first_n(first_o[1]), .tile_last_n(last_o[1]),
        .busy(busy_o[1]), .task_done(td_o[1])
    );

    // Free-running clock and a cycle counter used for latency measurements.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Single comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one vector's inputs for one cycle and samples after the edge.
    task automatic applyStimulus(input int inst, input vec_t v);
        rst_s[inst]   = v.rst;
        start_s[inst] = v.start;
        ld_s[inst]    = v.ld;
        cd_s[inst]    = v.cd;
        sd_s[inst]    = v.sd;
        @(posedge clk);
        #1;
    endtask

    // Outputs expected while idle after reset, derived from the layer shape.
    task automatic checkReset(input int inst, input string tag);
        checkOutput({tag, ".busy"},   busy_o[inst], 0);
        checkOutput({tag, ".ls"},     ls_o[inst], 0);
        checkOutput({tag, ".cs"},     cs_o[inst], 0);
        checkOutput({tag, ".ss"},     ss_o[inst], 0);
        checkOutput({tag, ".td"},     td_o[inst], 0);
        checkOutput({tag, ".bases"},  int'(bm[inst]) + int'(br[inst]) + int'(bc[inst]) + int'(bn[inst]), 0);
        checkOutput({tag, ".len_m"},  lm[inst], min2(tm[inst], pm[inst]));
        checkOutput({tag, ".len_r"},  lr[inst], min2(tr[inst], pr[inst]));
        checkOutput({tag, ".len_c"},  lc[inst], min2(tc[inst], pc[inst]));
        checkOutput({tag, ".len_n"},  ln[inst], min2(tn[inst], pn[inst]));
        checkOutput({tag, ".first"},  first_o[inst], 1);
        checkOutput({tag, ".last"},   last_o[inst], (tn[inst] >= pn[inst]) ? 1 : 0);
    endtask

    // Runs one layer. mode 0: dones 3 cycles after each start; mode 1: dones
    // in the same cycle as the start; mode 2: random 0..4 cycle latency.
    // spur injects done/start pulses in states that must ignore them.
    // abort_at > 0 applies rst during the COMP of that load/compute step.
    task automatic runLayer(input int inst, input int mode, input bit spur,
                            input int abort_at, input string tag);
        tile_t tq [$];
        tile_t e;
        int n_ld, n_cp, n_st, n_td, idx, t0, t_done;
        int cnt_l, cnt_c, cnt_s, exp_st, lat;
        bit td_seen, finished, quiet;

        for (int m = 0; m < pm[inst]; m += tm[inst])
            for (int r = 0; r < pr[inst]; r += tr[inst])
                for (int c = 0; c < pc[inst]; c += tc[inst])
                    for (int n = 0; n < pn[inst]; n += tn[inst]) begin
                        e.m  = m;  e.row = r;  e.col = c;  e.n = n;
                        e.lm = min2(tm[inst], pm[inst] - m);
                        e.lr = min2(tr[inst], pr[inst] - r);
                        e.lc = min2(tc[inst], pc[inst] - c);
                        e.ln = min2(tn[inst], pn[inst] - n);
                        e.first = (n == 0);
                        e.last  = (n + tn[inst] >= pn[inst]);
                        tq.push_back(e);
                    end
        exp_st = 0;
        foreach (tq[i]) if (tq[i].last) exp_st++;

        n_ld = 0; n_cp = 0; n_st = 0; n_td = 0; idx = 0; t_done = 0;
        cnt_l = -1; cnt_c = -1; cnt_s = -1;
        td_seen = 0; finished = 0;

        start_s[inst] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start_s[inst] = 1'b0;

        for (int k = 0; k < 4000 && !finished; k++) begin
            ld_s[inst] = 0; cd_s[inst] = 0; sd_s[inst] = 0; spur_s[inst] = 0;
            if (td_seen) begin
                checkOutput({tag, ".busy_after_done"}, busy_o[inst], 0);
                checkOutput({tag, ".single_done"}, td_o[inst], 0);
                finished = 1;
            end else begin
                lat = (mode == 0) ? 3 : (mode == 1) ? 0 : int'($urandom_range(0, 4));
                if (ls_o[inst]) begin
                    n_ld++;
                    cnt_l = lat;
                    if (idx < tq.size()) begin
                        e = tq[idx];
                        tests++;
                        if (int'(bm[inst]) != e.m || int'(br[inst]) != e.row ||
                            int'(bc[inst]) != e.col || int'(bn[inst]) != e.n ||
                            int'(lm[inst]) != e.lm || int'(lr[inst]) != e.lr ||
                            int'(lc[inst]) != e.lc || int'(ln[inst]) != e.ln ||
                            first_o[inst] != e.first || last_o[inst] != e.last) begin
                            failed++;
                            $display("[TB] FAIL %s.tile%0d: got base %0d/%0d/%0d/%0d len %0d/%0d/%0d/%0d f%0b l%0b, expected base %0d/%0d/%0d/%0d len %0d/%0d/%0d/%0d f%0b l%0b",
                                     tag, idx, bm[inst], br[inst], bc[inst], bn[inst],
                                     lm[inst], lr[inst], lc[inst], ln[inst], first_o[inst], last_o[inst],
                                     e.m, e.row, e.col, e.n, e.lm, e.lr, e.lc, e.ln, e.first, e.last);
                        end
                    end
                    idx++;
                    if (spur) sd_s[inst] = 1'b1;
                end
                if (cs_o[inst]) begin
                    n_cp++;
                    cnt_c = lat;
                    if (spur) spur_s[inst] = 1'b1;
                    if (abort_at > 0 && n_cp == abort_at) begin
                        rst_s[inst] = 1'b1;
                        @(posedge clk);
                        #1;
                        rst_s[inst] = 1'b0;
                        checkReset(inst, {tag, ".after_rst"});
                        quiet = 1;
                        for (int q = 0; q < 10; q++) begin
                            if (td_o[inst] || ls_o[inst] || cs_o[inst] || ss_o[inst] || busy_o[inst]) quiet = 0;
                            @(posedge clk);
                            #1;
                        end
                        checkOutput({tag, ".quiet_after_rst"}, quiet, 1);
                        return;
                    end
                end
                if (ss_o[inst]) begin
                    n_st++;
                    cnt_s = lat;
                    checkOutput({tag, ".store_after_last_n"}, last_o[inst], 1);
                    if (spur) cd_s[inst] = 1'b1;
                end
                if (td_o[inst]) begin
                    n_td++;
                    t_done = cyc;
                    td_seen = 1;
                    checkOutput({tag, ".busy_at_done"}, busy_o[inst], 1);
                end
                if (cnt_l == 0) begin ld_s[inst] = 1'b1; cnt_l = -1; end
                else if (cnt_l > 0) cnt_l--;
                if (cnt_c == 0) begin cd_s[inst] = 1'b1; cnt_c = -1; end
                else if (cnt_c > 0) cnt_c--;
                if (cnt_s == 0) begin sd_s[inst] = 1'b1; cnt_s = -1; end
                else if (cnt_s > 0) cnt_s--;
            end
            if (!finished) begin
                @(posedge clk);
                #1;
            end
        end
        ld_s[inst] = 0; cd_s[inst] = 0; sd_s[inst] = 0; spur_s[inst] = 0;

        checkOutput({tag, ".completed"}, finished, 1);
        checkOutput({tag, ".loads"},  n_ld, tq.size());
        checkOutput({tag, ".comps"},  n_cp, tq.size());
        checkOutput({tag, ".stores"}, n_st, exp_st);
        checkOutput({tag, ".task_done"}, n_td, 1);
        if (mode == 1)
            checkOutput({tag, ".min_cycles"}, t_done - t0, 2 * tq.size() + exp_st + 1);
    endtask

    vec_t vecs [14];

    initial begin
        pm = '{16, 8};  pr = '{16, 8};  pc = '{16, 20};  pn = '{16, 24};
        tm = '{8, 8};   tr = '{8, 8};   tc = '{8, 8};    tn = '{8, 8};

        //          rst st ld cd sd | ls cs ss bsy td  bn  bc  f  l
        vecs[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  1, 0};
        vecs[1]  = '{0, 1, 0, 0, 0,   1, 0, 0, 1,  0,  0,  0,  1, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1,  0,  0,  0,  1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1,   0, 0, 0, 1,  0,  0,  0,  1, 0};
        vecs[4]  = '{0, 0, 1, 0, 0,   0, 1, 0, 1,  0,  0,  0,  1, 0};
        vecs[5]  = '{0, 0, 0, 1, 0,   1, 0, 0, 1,  0,  8,  0,  0, 1};
        vecs[6]  = '{0, 0, 1, 0, 0,   0, 1, 0, 1,  0,  8,  0,  0, 1};
        vecs[7]  = '{0, 1, 0, 0, 0,   0, 0, 0, 1,  0,  8,  0,  0, 1};
        vecs[8]  = '{0, 0, 0, 1, 0,   0, 0, 1, 1,  0,  8,  0,  0, 1};
        vecs[9]  = '{0, 0, 0, 1, 0,   0, 0, 0, 1,  0,  8,  0,  0, 1};
        vecs[10] = '{0, 0, 0, 0, 1,   1, 0, 0, 1,  0,  0,  8,  1, 0};
        vecs[11] = '{0, 0, 1, 0, 0,   0, 1, 0, 1,  0,  0,  8,  1, 0};
        vecs[12] = '{1, 0, 0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  1, 0};
        vecs[13] = '{0, 0, 0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  1, 0};

        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1; start_s[i] = 0; spur_s[i] = 0;
            ld_s[i] = 0; cd_s[i] = 0; sd_s[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_s[0] = 0;
        rst_s[1] = 0;
        @(posedge clk);
        #1;
        checkReset(0, "reset0");
        checkReset(1, "reset1");

        $display("[TB] cycle-by-cycle handshake vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, vecs[i]);
            checkOutput($sformatf("v%0d.ls", i),    ls_o[0],    vecs[i].ls);
            checkOutput($sformatf("v%0d.cs", i),    cs_o[0],    vecs[i].cs);
            checkOutput($sformatf("v%0d.ss", i),    ss_o[0],    vecs[i].ss);
            checkOutput($sformatf("v%0d.busy", i),  busy_o[0],  vecs[i].busy);
            checkOutput($sformatf("v%0d.td", i),    td_o[0],    vecs[i].td);
            checkOutput($sformatf("v%0d.bn", i),    bn[0],      vecs[i].bn);
            checkOutput($sformatf("v%0d.bc", i),    bc[0],      vecs[i].bc);
            checkOutput($sformatf("v%0d.first", i), first_o[0], vecs[i].first);
            checkOutput($sformatf("v%0d.last", i),  last_o[0],  vecs[i].last);
        end

        $display("[TB] full walk, latency 3");
        runLayer(0, 0, 0, 0, "walk");
        $display("[TB] immediate handshake");
        runLayer(0, 1, 0, 0, "immediate");
        $display("[TB] spurious pulses");
        runLayer(0, 0, 1, 0, "spurious");
        $display("[TB] reset during 5th compute");
        runLayer(0, 0, 0, 5, "abort");
        runLayer(0, 0, 0, 0, "restart");
        $display("[TB] random latency");
        runLayer(0, 2, 0, 0, "rand0a");
        runLayer(0, 2, 1, 0, "rand0b");
        $display("[TB] ragged cols and multi n-tile accumulation");
        runLayer(1, 0, 0, 0, "ragged");
        runLayer(1, 1, 0, 0, "ragged_imm");
        runLayer(1, 2, 0, 0, "ragged_rand");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/conv_tile_sched.md
# conv_tile_sched

Tile-loop scheduler for the convolution accelerator. It walks output tiles (m, row, col) and input-channel tiles (n), and for each step it sequences the load, compute and store engines through start/done pulse handshakes. It presents the current tile bases and edge-clipped tile lengths to the per-buffer config blocks such as the input-feature-map transfer config. It runs once per layer, from a `start` pulse to a `task_done` pulse.

## Interface
- `CW`, 8: width of base/length counters; requires 2^CW > max(M,R,C,N) + max(Tm,Tr,Tc,Tn)
- `M`, 32: output channels
- `R`, 32: output rows
- `C`, 32: output cols
- `N`, 32: input channels
- `Tm`, 8: output-channel tile size (≥1)
- `Tr`, 8: row tile size (≥1)
- `Tc`, 8: col tile size (≥1)
- `Tn`, 8: input-channel tile size (≥1)

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  layer start pulse
- `load_start`  out  1  one-cycle pulse: load in_fm + weights for the current tile
- `load_done`  in  1  load complete pulse
- `comp_start`  out  1  one-cycle pulse: compute the current n-tile
- `comp_done`  in  1  compute complete pulse
- `store_start`  out  1  one-cycle pulse: store the out_fm tile
- `store_done`  in  1  store complete pulse
- `tile_base_m`, `tile_base_row`, `tile_base_col`, `tile_base_n`  out  CW each  current tile origin
- `tile_len_m`, `tile_len_row`, `tile_len_col`, `tile_len_n`  out  CW each  clipped tile extent
- `tile_first_n`  out  1  current n-tile is the first; the accumulator clears
- `tile_last_n`  out  1  current n-tile is the last; the store follows
- `busy`  out  1  high from the cycle after an accepted start through the task_done cycle
- `task_done`  out  1  one-cycle pulse when the layer is complete

## Operation
- States: IDLE, LOAD, COMP, STORE, FIN.
- IDLE + `start` → LOAD. All bases are 0.
- LOAD: wait for `load_done`, then go to COMP.
- COMP: on `comp_done`:
  - if `tile_last_n` is 0, advance n and go to LOAD;
  - else go to STORE.
- STORE: on `store_done`:
  - if this is the last output tile, go to FIN;
  - else advance (m, row, col), set n = 0, and go to LOAD.
- FIN: pulse `task_done`, clear all bases to 0, go to IDLE.
- Loop order is n innermost, then col, then row, with m outermost. Each base steps by its tile size.
- A wrap occurs when base + T ≥ limit. The sum is computed in CW+1 bits, so it has no overflow.
- The last output tile is the point where the m, row and col wraps all occur together.
- Clipping: `tile_len_x` = (base_x + Tx > X) ? X − base_x : Tx. Example: C=20, Tc=8 gives col lengths 8, 8, 4.
- Derived flags:
  - `tile_first_n` = (base_n == 0)
  - `tile_last_n` = (base_n + Tn ≥ N)
- Each `*_start` pulse is high in the first cycle of its state only.
- A `*_done` pulse is accepted only in its matching state, including the cycle its start is high.
- Done pulses arriving in any other state are ignored.
- `start` is ignored while `busy` is high.

## Timing
- Reset values: state IDLE; all outputs 0, except:
  - `tile_len_*` = min(T, X) of the reset bases;
  - `tile_first_n` = 1;
  - `tile_last_n` = (Tn ≥ N).
- `rst` mid-operation returns to IDLE on the next edge. Pending dones are dropped, and no `task_done` is emitted.
- All outputs are registered, and bases/lengths/flags are stable for the whole tile.
- `start` at cycle t → `load_start` and `busy` at t+1.
- A done pulse at cycle t → the next start pulse at t+1, with the new bases already valid at t+1.
- Bases update on the same edge that issues the next `load_start`.
- The final `store_done` at cycle t → `task_done` at t+1 and `busy` low at t+2.
- Totals per layer, with ceil() per dimension:
  - loads = comps = ceil(M/Tm) · ceil(R/Tr) · ceil(C/Tc) · ceil(N/Tn);
  - stores = ceil(M/Tm) · ceil(R/Tr) · ceil(C/Tc).
- Idle-to-idle minimum with dones returned immediately is 1 + 2·loads + stores + 1 cycles.

## Test plan
- Full walk, M=R=C=N=16 and all T=8, with dones returned 3 cycles after each start:
  - exactly 16 load, 16 comp and 8 store pulses, then 1 `task_done`;
  - base sequence (m,row,col) = (0,0,0), (0,0,8), (0,8,0), … (8,8,8);
  - n toggles between 0 and 8 per tile.
- Ragged edges, C=20, Tc=8, R=8, M=8, N=8: col bases 0, 8, 16 with `tile_len_col` 8, 8, 4; 3 stores in total; `tile_last_n`=1 throughout.
- Immediate handshake, where each done is asserted in the same cycle as its start: the FSM advances one state per cycle, and `task_done` arrives exactly at the computed minimum cycle count.
- Spurious and duplicate pulses:
  - `store_done` during LOAD, `comp_done` during STORE, and `start` while busy are all ignored;
  - the pulse counts and base sequence are identical to the full-walk case.
- `rst` asserted mid-COMP on the 5th tile: next cycle state is IDLE with all outputs at reset values and no `task_done`; a new `start` restarts at bases (0,0,0,0).
- Accumulator flags with N=24, Tn=8: per tile, n = 0, 8, 16 with `tile_first_n` 1, 0, 0 and `tile_last_n` 0, 0, 1; `store_start` follows only the n=16 compute.
